// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
package spi_responder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rsp_state_t;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/spi_responder_rx_fifo.sv
// Synchronous FIFO with occupancy count; a pop on empty is ignored and a push
// when full is accepted only if a pop happens in the same cycle.
module rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled SCK/CS_N/MOSI, RX bytes into a FIFO,
// TX bytes from a single holding register shifted out MSB first on MISO.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  TX_IDLE_BYTE = 8'hFF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          SPI_SCK,
  input  logic                          SPI_CS_N,
  input  logic                          SPI_MOSI,
  output logic                          SPI_MISO,
  output logic                          SPI_MISO_OE,
  input  logic [7:0]                    TX_BYTE,
  input  logic                          TX_LOAD,
  output logic                          TX_EMPTY,
  output logic [7:0]                    RX_BYTE,
  output logic                          RX_VALID,
  input  logic                          RX_POP,
  output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
  output logic                          RX_OVF,
  input  logic                          CLR_OVF,
  output logic                          FRAME_DONE,
  output logic                          INTR
);

  localparam int unsigned BCW = $clog2(BITS_PER_BYTE);

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  spi_rsp_state_t state_q, state_d;

  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic [7:0]     tx_hold_q, tx_hold_d;
  logic           tx_empty_q, tx_empty_d;
  logic           byte_done_q, byte_done_d;
  logic           push_q, push_d;
  logic [7:0]     push_data_q, push_data_d;
  logic           ovf_q, ovf_d;
  logic           frame_done_q, frame_done_d;
  logic           tx_load_ev;
  logic           fifo_full, fifo_empty;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s &  sck_dly_q;
  assign cs_rise  =  cs_s  & ~cs_dly_q;
  assign cs_fall  = ~cs_s  &  cs_dly_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SPI_MISO_OE = (state_q == SHIFT);
    SPI_MISO    = (state_q == SHIFT) ? tx_shift_q[7] : 1'b0;
  end

  // The fall after the 8th rise reloads tx_shift instead of shifting it.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    byte_done_d  = byte_done_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    tx_load_ev   = 1'b0;
    frame_done_d = (state_q == SHIFT) && cs_rise;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        bit_cnt_d   = '0;
        byte_done_d = 1'b0;
        tx_load_ev  = 1'b1;
      end
    end else if (!cs_rise) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == BCW'(BITS_PER_BYTE - 1)) begin
          push_d      = 1'b1;
          push_data_d = {rx_shift_q[6:0], mosi_s};
          byte_done_d = 1'b1;
        end
      end
      if (sck_fall) begin
        if (byte_done_q) begin
          tx_load_ev  = 1'b1;
          byte_done_d = 1'b0;
        end else begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
    end
    if (tx_load_ev) tx_shift_d = tx_empty_q ? TX_IDLE_BYTE : tx_hold_q;
  end

  // A TX_LOAD coinciding with a shift-register load refills the holding register.
  always_comb begin
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    if (tx_load_ev) tx_empty_d = 1'b1;
    if (TX_LOAD) begin
      tx_hold_d  = TX_BYTE;
      tx_empty_d = 1'b0;
    end
  end

  assign ovf_d = (ovf_q & ~CLR_OVF) | (push_q & fifo_full & ~RX_POP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      tx_hold_q    <= '0;
      tx_empty_q   <= 1'b1;
      byte_done_q  <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_hold_q    <= tx_hold_d;
      tx_empty_q   <= tx_empty_d;
      byte_done_q  <= byte_done_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (RX_POP),
    .data_o  (RX_BYTE),
    .count_o (RX_COUNT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign RX_VALID   = ~fifo_empty;
  assign RX_OVF     = ovf_q;
  assign TX_EMPTY   = tx_empty_q;
  assign FRAME_DONE = frame_done_q;
  assign INTR       = RX_VALID | ovf_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed scenarios plus randomized frames checked
// against a queue-based model of the RX FIFO, overflow flag and TX holding register.
module tb_spi_responder;

  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SPI_SCK, SPI_CS_N, SPI_MOSI;
  logic       SPI_MISO, SPI_MISO_OE;
  logic [7:0] TX_BYTE;
  logic       TX_LOAD, TX_EMPTY;
  logic [7:0] RX_BYTE;
  logic       RX_VALID, RX_POP;
  logic [2:0] RX_COUNT;
  logic       RX_OVF, CLR_OVF, FRAME_DONE, INTR;

  always #5 CLK = ~CLK;

  spi_responder #(
    .FIFO_DEPTH   (DEPTH),
    .TX_IDLE_BYTE (8'hFF)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SPI_SCK     (SPI_SCK),
    .SPI_CS_N    (SPI_CS_N),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .SPI_MISO_OE (SPI_MISO_OE),
    .TX_BYTE     (TX_BYTE),
    .TX_LOAD     (TX_LOAD),
    .TX_EMPTY    (TX_EMPTY),
    .RX_BYTE     (RX_BYTE),
    .RX_VALID    (RX_VALID),
    .RX_POP      (RX_POP),
    .RX_COUNT    (RX_COUNT),
    .RX_OVF      (RX_OVF),
    .CLR_OVF     (CLR_OVF),
    .FRAME_DONE  (FRAME_DONE),
    .INTR        (INTR)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model
  logic [7:0]  m_fifo[$];
  bit          m_ovf;
  bit          m_hold_full;
  logic [7:0]  m_hold;
  int unsigned m_frames;
  int unsigned fd_cnt = 0;
  logic [7:0]  mosi_q[$];

  always @(negedge CLK) if (FRAME_DONE === 1'b1) fd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_ovf       = 1'b0;
    m_hold_full = 1'b0;
    m_hold      = 8'h00;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".count"},    32'(RX_COUNT),    32'(m_fifo.size()));
    check_eq({tag, ".valid"},    32'(RX_VALID),    32'(m_fifo.size() != 0));
    check_eq({tag, ".ovf"},      32'(RX_OVF),      32'(m_ovf));
    check_eq({tag, ".intr"},     32'(INTR),        32'((m_fifo.size() != 0) || m_ovf));
    check_eq({tag, ".tx_empty"}, 32'(TX_EMPTY),    32'(!m_hold_full));
    check_eq({tag, ".frames"},   fd_cnt,           m_frames);
    check_eq({tag, ".oe"},       32'(SPI_MISO_OE), 32'(0));
    check_eq({tag, ".miso"},     32'(SPI_MISO),    32'(0));
  endtask

  task automatic tx_load(input logic [7:0] b);
    TX_BYTE = b;
    TX_LOAD = 1'b1;
    tick(1);
    TX_LOAD = 1'b0;
    m_hold      = b;
    m_hold_full = 1'b1;
    check_eq("tx_load.empty", 32'(TX_EMPTY), 32'(0));
  endtask

  task automatic pop_one(input string tag);
    check_eq({tag, ".valid"}, 32'(RX_VALID), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check_eq({tag, ".byte"}, 32'(RX_BYTE), 32'(m_fifo[0]));
    RX_POP = 1'b1;
    tick(1);
    RX_POP = 1'b0;
    if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    check_eq({tag, ".count"}, 32'(RX_COUNT), 32'(m_fifo.size()));
  endtask

  task automatic clr_ovf();
    CLR_OVF = 1'b1;
    tick(1);
    CLR_OVF = 1'b0;
    m_ovf = 1'b0;
    check_eq("clr_ovf", 32'(RX_OVF), 32'(0));
  endtask

  // Master side: SCK half period = 4 CLK, MOSI set while SCK low, MISO sampled at SCK rise.
  task automatic frame(input int unsigned nbits, input bit pop_last, input string tag);
    logic [7:0] exp0, cap, b;
    exp0 = m_hold_full ? m_hold : 8'hFF;
    m_hold_full = 1'b0;
    cap = 8'h00;
    SPI_CS_N = 1'b0;
    tick(8);
    check_eq({tag, ".oe_on"}, 32'(SPI_MISO_OE), 32'(1));
    check_eq({tag, ".tx_empty_after_load"}, 32'(TX_EMPTY), 32'(1));
    for (int i = 0; i < int'(nbits); i++) begin
      b = mosi_q[i / 8];
      SPI_MOSI = b[7 - (i % 8)];
      tick(4);
      SPI_SCK = 1'b1;
      cap = {cap[6:0], SPI_MISO};
      if (i % 8 == 7) begin
        check_eq({tag, ".miso_byte"}, 32'(cap), (i / 8 == 0) ? 32'(exp0) : 32'hFF);
        tick(3);
        check_eq({tag, ".pre_push_count"}, 32'(RX_COUNT), 32'(m_fifo.size()));
        if (pop_last && i == int'(nbits) - 1) begin
          if (m_fifo.size() != 0) check_eq({tag, ".pop_head"}, 32'(RX_BYTE), 32'(m_fifo[0]));
          RX_POP = 1'b1;
          if (m_fifo.size() != 0) void'(m_fifo.pop_front());
        end
        tick(1);
        RX_POP = 1'b0;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
        else m_ovf = 1'b1;
        check_eq({tag, ".rx_valid_4clk"}, 32'(RX_VALID), 32'(1));
        check_eq({tag, ".post_push_count"}, 32'(RX_COUNT), 32'(m_fifo.size()));
      end else begin
        tick(4);
      end
      SPI_SCK = 1'b0;
    end
    tick(8);
    SPI_CS_N = 1'b1;
    m_frames++;
    tick(8);
    check_status({tag, ".end"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nbytes, nbits;
    RST = 1'b1; SPI_SCK = 1'b0; SPI_CS_N = 1'b1; SPI_MOSI = 1'b0;
    TX_BYTE = 8'h00; TX_LOAD = 1'b0; RX_POP = 1'b0; CLR_OVF = 1'b0;
    m_frames = 0;
    model_reset();
    tick(3);
    check_status("reset");
    RST = 1'b0;
    tick(4);

    // Single byte receive
    mosi_q = '{8'hA5};
    frame(8, 1'b0, "rx_a5");
    pop_one("rx_a5.pop");

    // Full duplex: loaded byte then idle byte
    tx_load(8'h3C);
    mosi_q = '{8'h00, 8'h00};
    frame(16, 1'b0, "duplex");
    pop_one("duplex.pop0");
    pop_one("duplex.pop1");

    // Overflow
    mosi_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame(40, 1'b0, "ovf");
    for (int i = 0; i < 5; i++) pop_one("ovf.pop");
    clr_ovf();

    // Simultaneous push and pop on a full FIFO
    mosi_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    frame(32, 1'b0, "full_fill");
    mosi_q = '{8'h05};
    frame(8, 1'b1, "full_pushpop");
    for (int i = 0; i < 4; i++) pop_one("full_pushpop.pop");

    // SCK activity while deselected is ignored
    for (int i = 0; i < 6; i++) begin
      SPI_SCK = ~SPI_SCK;
      tick(4);
    end
    SPI_SCK = 1'b0;
    tick(4);
    check_status("idle_sck");

    // Aborted frame, then a normal one
    mosi_q = '{8'hFF};
    frame(5, 1'b0, "abort");
    mosi_q = '{8'h81};
    frame(8, 1'b0, "after_abort");
    pop_one("after_abort.pop");

    // Reset mid-byte
    tx_load(8'h77);
    SPI_CS_N = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      SPI_MOSI = 1'b1;
      tick(4);
      SPI_SCK = 1'b1;
      tick(4);
      SPI_SCK = 1'b0;
    end
    RST = 1'b1;
    SPI_CS_N = 1'b1;
    model_reset();
    tick(2);
    check_status("mid_reset");
    RST = 1'b0;
    tick(4);
    mosi_q = '{8'h5A};
    frame(8, 1'b0, "after_reset");
    pop_one("after_reset.pop");

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(1, 0) == 1) tx_load(8'($urandom));
      nbytes = $urandom_range(3, 1);
      mosi_q.delete();
      for (int j = 0; j < int'(nbytes); j++) mosi_q.push_back(8'($urandom));
      nbits = nbytes * 8;
      if ($urandom_range(4, 0) == 0) nbits = nbits - $urandom_range(7, 1);
      frame(nbits, ($urandom_range(3, 0) == 0), "rand");
      for (int p = 0; p < int'($urandom_range(3, 0)); p++) pop_one("rand.pop");
      if ($urandom_range(2, 0) == 0) clr_ovf();
    end
    while (m_fifo.size() != 0) pop_one("drain");
    pop_one("drain.empty");
    check_status("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
